// File: rtl/videoout_gen.sv
// Video output stage: pixel/border/black select, two-bank line buffer scan doubler,
// and DAC colour plus sync drive with matched latency in TV and VGA modes.
module videoout_gen #(
  parameter int CW  = 2,
  parameter int LBW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3*CW-1:0] pixel,
  input  logic [3*CW-1:0] border,
  input  logic            hblank,
  input  logic            vblank,
  input  logic            hpix,
  input  logic            vpix,
  input  logic            pix_stb,
  input  logic            hsync,
  input  logic            vsync,
  input  logic            vga_hsync,
  input  logic            scanin_start,
  input  logic            scanout_start,
  input  logic            cfg_vga_on,
  input  logic            cfg_hs_neg,
  input  logic            cfg_vs_neg,
  output logic [CW-1:0]   vred,
  output logic [CW-1:0]   vgrn,
  output logic [CW-1:0]   vblu,
  output logic            vhsync,
  output logic            vvsync,
  output logic            vcsync
);

  localparam int         DEPTH = 2**LBW;
  localparam logic [LBW:0] PMAX = {1'b1, {LBW{1'b0}}};

  logic [3*CW-1:0] color;
  logic [3*CW-1:0] mem [2][DEPTH];

  logic            wbank_q, wbank_d;
  logic [LBW:0]    wptr_q, wptr_d;
  logic [1:0][LBW:0] len_q, len_d;
  logic [LBW:0]    waddr;
  logic            wr_en;

  logic            rbank;
  logic [LBW:0]    rptr_q, rptr_d;
  logic [3*CW-1:0] rd_mem_q, rd_mem_d;
  logic            rd_ok_q, rd_ok_d;

  logic [3*CW-1:0] col_q, col_d;
  logic            hs_dly_q, hs_dly_d;
  logic            vhsync_q, vhsync_d;
  logic            vvsync_q, vvsync_d;
  logic            vcsync_q, vcsync_d;

  always_comb begin
    color = '0;
    if (!(hblank || vblank))
      color = (hpix && vpix) ? pixel : border;
  end

  // A new line toggles the bank first, so a coincident strobe lands at address 0
  // of the new bank.
  always_comb begin
    wbank_d = wbank_q;
    wptr_d  = wptr_q;
    len_d   = len_q;
    waddr   = wptr_q;
    wr_en   = 1'b0;
    if (scanin_start) begin
      wbank_d        = ~wbank_q;
      len_d[wbank_q] = wptr_q;
      waddr          = '0;
      wptr_d         = '0;
    end
    if (pix_stb && !rst && (waddr != PMAX)) begin
      wr_en  = 1'b1;
      wptr_d = waddr + (LBW+1)'(1);
    end
  end

  // Reading with the next pointer value keeps rptr_q aligned to the data in rd_mem_q;
  // using the next bank/len lets a coincident scanin/scanout read the fresh line.
  always_comb begin
    rbank = ~wbank_d;
    if (scanout_start)
      rptr_d = '0;
    else if (rptr_q != PMAX)
      rptr_d = rptr_q + (LBW+1)'(1);
    else
      rptr_d = rptr_q;
    rd_mem_d = mem[rbank][rptr_d[LBW-1:0]];
    rd_ok_d  = (rptr_d < len_d[rbank]);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wbank_d][waddr[LBW-1:0]] <= color;
  end

  always_comb begin
    col_d    = cfg_vga_on ? (rd_ok_q ? rd_mem_q : '0) : color;
    hs_dly_d = vga_hsync;
    vhsync_d = (cfg_vga_on ? hs_dly_q : hsync) ^ cfg_hs_neg;
    vvsync_d = vsync ^ cfg_vs_neg;
    vcsync_d = ~(hsync ^ vsync);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q  <= 1'b0;
      wptr_q   <= '0;
      len_q    <= '0;
      rptr_q   <= '0;
      rd_mem_q <= '0;
      rd_ok_q  <= 1'b0;
      col_q    <= '0;
      hs_dly_q <= 1'b0;
      vhsync_q <= cfg_hs_neg;
      vvsync_q <= cfg_vs_neg;
      vcsync_q <= 1'b1;
    end else begin
      wbank_q  <= wbank_d;
      wptr_q   <= wptr_d;
      len_q    <= len_d;
      rptr_q   <= rptr_d;
      rd_mem_q <= rd_mem_d;
      rd_ok_q  <= rd_ok_d;
      col_q    <= col_d;
      hs_dly_q <= hs_dly_d;
      vhsync_q <= vhsync_d;
      vvsync_q <= vvsync_d;
      vcsync_q <= vcsync_d;
    end
  end

  assign vred   = col_q[3*CW-1:2*CW];
  assign vgrn   = col_q[2*CW-1:CW];
  assign vblu   = col_q[CW-1:0];
  assign vhsync = vhsync_q;
  assign vvsync = vvsync_q;
  assign vcsync = vcsync_q;

endmodule

// File: tb/tb_videoout_gen.sv
// Directed bench for videoout_gen: a default-size instance and an LBW=3 instance
// share stimulus so line-length saturation can be seen against an unsaturated line.
module tb_videoout_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] pixel, border;
  logic       hblank, vblank, hpix, vpix, pix_stb;
  logic       hsync, vsync, vga_hsync, scanin_start, scanout_start;
  logic       cfg_vga_on, cfg_hs_neg, cfg_vs_neg;

  logic [1:0] a_r, a_g, a_b, s_r, s_g, s_b;
  logic       a_hs, a_vs, a_cs, s_hs, s_vs, s_cs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  videoout_gen #(.CW(2), .LBW(10)) u_dut (
    .clk(clk), .rst(rst), .pixel(pixel), .border(border),
    .hblank(hblank), .vblank(vblank), .hpix(hpix), .vpix(vpix), .pix_stb(pix_stb),
    .hsync(hsync), .vsync(vsync), .vga_hsync(vga_hsync),
    .scanin_start(scanin_start), .scanout_start(scanout_start),
    .cfg_vga_on(cfg_vga_on), .cfg_hs_neg(cfg_hs_neg), .cfg_vs_neg(cfg_vs_neg),
    .vred(a_r), .vgrn(a_g), .vblu(a_b), .vhsync(a_hs), .vvsync(a_vs), .vcsync(a_cs)
  );

  videoout_gen #(.CW(2), .LBW(3)) u_sat (
    .clk(clk), .rst(rst), .pixel(pixel), .border(border),
    .hblank(hblank), .vblank(vblank), .hpix(hpix), .vpix(vpix), .pix_stb(pix_stb),
    .hsync(hsync), .vsync(vsync), .vga_hsync(vga_hsync),
    .scanin_start(scanin_start), .scanout_start(scanout_start),
    .cfg_vga_on(cfg_vga_on), .cfg_hs_neg(cfg_hs_neg), .cfg_vs_neg(cfg_vs_neg),
    .vred(s_r), .vgrn(s_g), .vblu(s_b), .vhsync(s_hs), .vvsync(s_vs), .vcsync(s_cs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pixel = '0; border = '0; hblank = 0; vblank = 0; hpix = 0; vpix = 0;
    pix_stb = 0; hsync = 0; vsync = 0; vga_hsync = 0; scanin_start = 0; scanout_start = 0;
    cfg_vga_on = 0; cfg_hs_neg = 1; cfg_vs_neg = 0;

    // reset state
    tick(); tick();
    chk("rst_col", {2'b0, a_r, a_g, a_b}, 8'h00);
    chk("rst_hs", {7'b0, a_hs}, 8'h01);
    chk("rst_vs", {7'b0, a_vs}, 8'h00);
    chk("rst_cs", {7'b0, a_cs}, 8'h01);
    cfg_hs_neg = 0;
    rst = 1'b0;

    // TV colour select
    hpix = 1; vpix = 1; pixel = 6'b110110; border = 6'b000111;
    tick();
    chk("tv_red", {6'b0, a_r}, 8'h03);
    chk("tv_grn", {6'b0, a_g}, 8'h01);
    chk("tv_blu", {6'b0, a_b}, 8'h02);
    hpix = 0;
    tick();
    chk("tv_border", {2'b0, a_r, a_g, a_b}, 8'h07);
    hpix = 1; hblank = 1;
    tick();
    chk("tv_hblank", {2'b0, a_r, a_g, a_b}, 8'h00);
    hblank = 0; vblank = 1;
    tick();
    chk("tv_vblank", {2'b0, a_r, a_g, a_b}, 8'h00);
    vblank = 0;

    // TV syncs
    vsync = 1;
    tick();
    chk("tv_vs", {7'b0, a_vs}, 8'h01);
    chk("tv_cs", {7'b0, a_cs}, 8'h00);
    vsync = 0;

    // line A: 8 strobes of colours 1..8
    for (int i = 1; i <= 8; i++) begin
      pixel = 6'(i); pix_stb = 1;
      tick();
    end
    pix_stb = 0;
    cfg_vga_on = 1; scanin_start = 1; scanout_start = 1;
    tick();
    scanin_start = 0; scanout_start = 0;
    chk("vga_a_lead", {2'b0, a_r, a_g, a_b}, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("vga_a", {2'b0, a_r, a_g, a_b}, 8'(k));
    end
    tick();
    chk("vga_a_tail", {2'b0, a_r, a_g, a_b}, 8'h00);
    tick();
    chk("vga_a_tail2", {2'b0, a_r, a_g, a_b}, 8'h00);

    // replay the same line
    scanout_start = 1;
    tick();
    scanout_start = 0;
    chk("replay_lead", {2'b0, a_r, a_g, a_b}, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("replay", {2'b0, a_r, a_g, a_b}, 8'(k));
    end
    tick();
    chk("replay_tail", {2'b0, a_r, a_g, a_b}, 8'h00);

    // line B: 12 strobes, the LBW=3 instance must keep only the first 8
    for (int i = 0; i < 12; i++) begin
      pixel = 6'(33 + i); pix_stb = 1;
      tick();
    end
    pix_stb = 0;
    scanin_start = 1; scanout_start = 1;
    tick();
    scanin_start = 0; scanout_start = 0;
    chk("sat_lead", {2'b0, s_r, s_g, s_b}, 8'h00);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("full_b", {2'b0, a_r, a_g, a_b}, 8'(33 + k));
      chk("sat_b", {2'b0, s_r, s_g, s_b}, (k < 8) ? 8'(33 + k) : 8'h00);
    end
    tick();
    chk("full_b_tail", {2'b0, a_r, a_g, a_b}, 8'h00);
    chk("sat_b_tail", {2'b0, s_r, s_g, s_b}, 8'h00);

    // TV hsync polarity
    cfg_vga_on = 0; cfg_hs_neg = 1; hsync = 0;
    tick();
    chk("tv_hs_idle", {7'b0, a_hs}, 8'h01);
    hsync = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tv_hs_neg", {7'b0, a_hs}, 8'h00);
    end
    hsync = 0;
    tick();
    chk("tv_hs_end", {7'b0, a_hs}, 8'h01);

    // VGA hsync polarity, two-cycle latency
    cfg_vga_on = 1; vga_hsync = 1;
    tick();
    chk("vga_hs_lat", {7'b0, a_hs}, 8'h01);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("vga_hs_neg", {7'b0, a_hs}, 8'h00);
    end
    vga_hsync = 0;
    tick();
    chk("vga_hs_neg4", {7'b0, a_hs}, 8'h00);
    tick();
    chk("vga_hs_end", {7'b0, a_hs}, 8'h01);

    // reset mid-line
    cfg_vga_on = 0; pixel = 6'h2a;
    for (int i = 0; i < 3; i++) begin
      pix_stb = 1;
      tick();
    end
    pix_stb = 0; cfg_vs_neg = 1; vsync = 1; hsync = 1; rst = 1;
    tick();
    chk("mrst_vs", {7'b0, a_vs}, 8'h01);
    chk("mrst_cs", {7'b0, a_cs}, 8'h01);
    chk("mrst_hs", {7'b0, a_hs}, 8'h01);
    chk("mrst_col", {2'b0, a_r, a_g, a_b}, 8'h00);
    rst = 0; hsync = 0; vsync = 0; cfg_vga_on = 1;
    scanin_start = 1; scanout_start = 1;
    tick();
    scanin_start = 0; scanout_start = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_black", {2'b0, a_r, a_g, a_b}, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
